// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. It performs one shift-add or restoring-subtract step per
// cycle, then a final cycle that applies sign correction and writes the result.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out
);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          rd_pend_q, rd_pend_d;
  logic                neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic                busy_q, busy_d, done_q, done_d, we_q, we_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          rd_out_q, rd_out_d;

  logic                a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]     a_abs, b_abs;
  logic [XLEN:0]       mul_sum, div_shift;
  logic [XLEN-1:0]     rem_sub;
  logic                div_ge;
  logic [2*XLEN-1:0]   mul_step, div_step, prod;
  logic [XLEN-1:0]     quo_fix, rem_fix;

  // Only MULHU, DIVU and REMU treat rs1 as unsigned; MULHSU additionally treats rs2 as unsigned.
  assign a_sgn = !(op[0] && (op[1] || op[2]));
  assign b_sgn = a_sgn && (op != 3'b010);
  assign a_neg = a_sgn && rs1_data[XLEN-1];
  assign b_neg = b_sgn && rs2_data[XLEN-1];
  assign a_abs = a_neg ? -rs1_data : rs1_data;
  assign b_abs = b_neg ? -rs2_data : rs2_data;

  // Multiply: the high half accumulates, the low half shifts the multiplier out.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

  // Divide: the high half is the partial remainder, the low half shifts dividend out, quotient in.
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign rem_sub   = div_shift[XLEN-1:0] - opnd_q;
  assign div_step  = {div_ge ? rem_sub : div_shift[XLEN-1:0], acc_q[XLEN-2:0], div_ge};

  assign prod    = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
  assign quo_fix = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    rd_pend_d = rd_pend_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    we_d      = 1'b0;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d      = op;
          rd_pend_d = rd_in;
          cnt_d     = '0;
          busy_d    = 1'b1;
          neg_a_d   = a_neg;
          neg_b_d   = b_neg;
          state_d   = StCalc;
          if (!op[2]) begin
            acc_d  = {{XLEN{1'b0}}, b_abs};
            opnd_d = a_abs;
          end else if (rs2_data == '0) begin
            // Fast paths preload {remainder, quotient} and disable sign correction.
            acc_d   = {rs1_data, {XLEN{1'b1}}};
            neg_a_d = 1'b0;
            neg_b_d = 1'b0;
            state_d = StFin;
          end else if (!op[0] && rs1_data == {1'b1, {(XLEN-1){1'b0}}} && rs2_data == '1) begin
            acc_d   = {{XLEN{1'b0}}, rs1_data};
            neg_a_d = 1'b0;
            neg_b_d = 1'b0;
            state_d = StFin;
          end else begin
            acc_d  = {{XLEN{1'b0}}, a_abs};
            opnd_d = b_abs;
          end
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 6'd1;
        acc_d = op_q[2] ? div_step : mul_step;
        if (cnt_q == 6'(XLEN - 1)) state_d = StFin;
      end
      StFin: begin
        unique case (op_q)
          3'b000:                 result_d = prod[XLEN-1:0];
          3'b001, 3'b010, 3'b011: result_d = prod[2*XLEN-1:XLEN];
          3'b100, 3'b101:         result_d = quo_fix;
          default:                result_d = rem_fix;
        endcase
        rd_out_d = rd_pend_q;
        done_d   = 1'b1;
        we_d     = rd_pend_q != 5'd0;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      rd_pend_q <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      rd_pend_q <= rd_pend_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      we_q      <= we_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign we_out = we_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected completions, a monitor pops on done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        busy, done, we_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out),
    .we_out   (we_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    int unsigned edge_n;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at edge %0d expected no done", cyc);
      end else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("rd_out", rd_out, 32'(e.rd));
        check("we_out", 32'(we_out), 32'(e.we));
        check("done_edge", cyc, e.edge_n);
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Called just after a rising edge with the unit idle; returns one cycle after accept.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input bit fast,
                       input bit push);
    exp_t x;
    x.res    = res;
    x.rd     = rd;
    x.we     = (rd != 5'd0);
    x.edge_n = cyc + 1 + (fast ? 1 : 33);
    if (push) sb.push_back(x);
    op = o; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL timeout: got busy=%0d pending=%0d expected idle", busy, sb.size());
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] res, input bit fast);
    issue(o, a, b, rd, res, fast, 1'b1);
    wait_idle();
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; op = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_we", 32'(we_out), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd_out", 32'(rd_out), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(3'b000, 32'd7,         32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0);
    run(3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 1'b0);
    run(3'b011, 32'h80000000,  32'd2,        5'd6,  32'h00000001, 1'b0);
    run(3'b001, 32'h80000000,  32'h80000000, 5'd10, 32'h40000000, 1'b0);
    run(3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd11, 32'hFFFFFFFF, 1'b0);
    run(3'b100, 32'hFFFFFFF9,  32'd2,        5'd12, 32'hFFFFFFFD, 1'b0);
    run(3'b110, 32'hFFFFFFF9,  32'd2,        5'd13, 32'hFFFFFFFF, 1'b0);
    run(3'b100, 32'd7,         32'hFFFFFFFE, 5'd12, 32'hFFFFFFFD, 1'b0);
    run(3'b110, 32'd7,         32'hFFFFFFFE, 5'd13, 32'h00000001, 1'b0);
    run(3'b101, 32'd100,       32'd7,        5'd14, 32'd14,       1'b0);
    run(3'b111, 32'd100,       32'd7,        5'd15, 32'd2,        1'b0);
    run(3'b101, 32'd5,         32'd0,        5'd16, 32'hFFFFFFFF, 1'b1);
    run(3'b110, 32'd5,         32'd0,        5'd17, 32'd5,        1'b1);
    run(3'b100, 32'h80000000,  32'hFFFFFFFF, 5'd18, 32'h80000000, 1'b1);
    run(3'b110, 32'h80000000,  32'hFFFFFFFF, 5'd19, 32'd0,        1'b1);
    run(3'b000, 32'd2,         32'd3,        5'd0,  32'd6,        1'b0);

    // Starts while busy must be ignored.
    issue(3'b000, 32'd3, 32'd5, 5'd7, 32'd15, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    op = 3'b101; rs1_data = 32'd9; rs2_data = 32'd0; rd_in = 5'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rd_out_held_while_busy", 32'(rd_out), 32'd0);
    wait_idle();
    check("rd_out_after_ignored_start", 32'(rd_out), 32'd7);

    // Back-to-back: second start lands in the done cycle.
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, 1'b0, 1'b1);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL b2b_first_done: got no done expected done within 100 cycles");
    end
    issue(3'b101, 32'd100, 32'd7, 5'd4, 32'd14, 1'b0, 1'b1);
    wait_idle();

    // Reset in cycle 10 of a divide aborts with no completion.
    issue(3'b100, 32'hFFFFFFF9, 32'd2, 5'd8, 32'd0, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_rd_out", 32'(rd_out), 32'd0);
    repeat (50) @(posedge clk);
    #1;
    check("abort_busy_later", 32'(busy), 32'd0);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage. It consumes the two register-file read operands and returns a 32-bit result, destination index and write enable. These go back to the register file write port (write data, write address, write enable). It runs one shift-add or restoring-subtract step per cycle and handles signed, unsigned and mixed-sign forms with a final sign-correction cycle.

## Interface

- `XLEN`, default 32. Operand and result width; the only supported value is 32.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; accepted only when `busy`=0.
- `op` in 3: RV32M funct3.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data` in 32: operand A (multiplicand / dividend).
- `rs2_data` in 32: operand B (multiplier / divisor).
- `rd_in` in 5: destination register index.
- `busy` out 1: operation in flight; `start` is ignored while high.
- `done` out 1: one-cycle pulse when the result is valid.
- `result` out 32: registered result; holds until the next completion or reset.
- `rd_out` out 5: destination index captured at accept.
- `we_out` out 1: equals `done` AND (`rd_out` != 0). Writes to x0 are suppressed.

## Operation

- **States:**
  - IDLE (`busy`=0).
  - CALC (`busy`=1; 32 iterations).
  - FIN (`busy`=1; sign correction and result write).
- **Accept, IDLE:** at an edge with `start`=1, latch `op` and `rd_in`, latch absolute-value operands and result-sign flags, clear the 6-bit iteration counter, and go to CALC.
- **Operand signedness:**
  - rs1 is signed for MUL, MULH, MULHSU, DIV, REM.
  - rs2 is signed for MUL, MULH, DIV, REM.
  - MUL low word is sign-independent, but must match the signed path.
- **Multiply, CALC:** 64-bit accumulator, one shift-add per cycle over 32 cycles.
  - FIN negates the 64-bit product if the sign flag is set.
  - FIN selects bits [31:0] for MUL and bits [63:32] for MULH/MULHSU/MULHU.
- **Divide, CALC:** restoring algorithm, one quotient bit per cycle over 32 cycles.
  - FIN negates the quotient if the operand signs differ.
  - FIN negates the remainder if the dividend was negative.
  - DIV/DIVU select the quotient; REM/REMU select the remainder.
- **Fast paths, detected at accept:** skip CALC and go straight to FIN.
  - Divisor zero: quotient 0xFFFFFFFF; remainder = rs1_data (unmodified).
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): quotient 0x80000000, remainder 0.
- **FIN:** write `result`, pulse `done`, return to IDLE.
- **Back-to-back:** a `start` in the same cycle as `done` is accepted; `busy` is already 0 in that cycle.
- **`start` while `busy`=1:** ignored. No queuing; latched operands and `rd_out` stay unchanged.
- **All arithmetic:** modulo 2^32 on the output. Internal accumulator is 64 bits; divider remainder is 33 bits.

## Timing

- **Reset values:** `busy`=0, `done`=0, `we_out`=0, `result`=0, `rd_out`=0, state IDLE, counter 0.
- **Reset mid-operation:** aborts at the next edge; outputs return to reset values; no `done` is produced.
- **Normal latency:** `start` sampled at edge N gives:
  - `busy`=1 after edges N through N+32;
  - `done`=1 for exactly one cycle after edge N+33;
  - `busy`=0 in that same cycle.
- **Fast-path latency:** `start` at edge N gives `done` after edge N+1.
- **Output stability:** `result` and `rd_out` change only at the edge that raises `done`.
- **Operand independence:** `rs1_data`, `rs2_data` and `op` may change freely after accept without affecting the operation.

## Test plan

- **MUL, MULHU:**
  - MUL 7 × 0xFFFFFFFD (−3), rd=5 → `result`=0xFFFFFFEB, `rd_out`=5, `we_out`=1, `done` 33 cycles after accept.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- **MULH, MULHSU:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Signed divide:**
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM −7 / 2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- **Special cases:**
  - DIVU 5/0 → 0xFFFFFFFF, `done` one cycle after accept.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- **Handshake:**
  - `start` pulsed at cycles 3 and 10 after a first accept → only the first completes; `rd_out` is unchanged.
  - New `start` in the `done` cycle → accepted; second `done` 34 cycles after the first.
- **Reset and x0:**
  - `rst`=1 at cycle 10 of a DIV → next cycle `busy`=0, `done`=0, `result`=0; no later `done`.
  - MUL with rd=0 → `done`=1, `we_out`=0.
